// File: rtl/video_pkg.sv
// Shared types and constants for the video output pipeline: palette ROM contents,
// pipeline depth and the RGB triple carried between stages.
package video_pkg;

   localparam int C_stages = 3;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   // 64-entry master palette, index = {luma[1:0], hue[3:0]}; hues D/E/F are black.
   localparam logic [23:0] C_palette [64] = '{
      24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
      24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
      24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
      24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
      24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
      24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
      24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'h000000, 24'h000000, 24'h000000
   };

   // Attenuate a channel to 3/4 of its value (floor); cannot underflow.
   function automatic logic [7:0] dim(input logic [7:0] v);
      return v - (v >> 2);
   endfunction

endpackage

// File: rtl/video_palette.sv
// Registered 64x24 palette ROM; the lookup result updates only when enable is high.
module video_palette
   import video_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [5:0] index,
   output rgb_t       rgb
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rgb <= '0;
      end else if (enable) begin
         rgb <= C_palette[index];
      end
   end

endmodule

// File: rtl/video_output_pipe.sv
// Three-stage pixel pipeline (capture, palette lookup, emphasis/blank) advancing on
// the pixel strobe, plus a frame counter driven by the falling edge of output vsync.
module video_output_pipe
   import video_pkg::*;
#(
   parameter int P_stages      = 3,
   parameter int P_frame_width = 16
) (
   input  logic                     I_clock,
   input  logic                     I_reset,
   input  logic                     I_rise,
   input  logic                     I_not_blank,
   input  logic                     I_hsync,
   input  logic                     I_vsync,
   input  logic [5:0]               I_pixel,
   input  logic                     I_greyscale,
   input  logic [2:0]               I_emphasis,
   output logic [7:0]               O_red,
   output logic [7:0]               O_green,
   output logic [7:0]               O_blue,
   output logic                     O_not_blank,
   output logic                     O_hsync,
   output logic                     O_vsync,
   output logic [P_frame_width-1:0] O_frame,
   output logic                     O_frame_start
);

   if (P_stages != C_stages) begin : g_stage_check
      $error("video_output_pipe: pipeline depth is fixed at 3");
   end

   logic [5:0]               s1_index;
   logic [2:0]               s1_emph;
   logic                     s1_nb, s1_hs, s1_vs;
   rgb_t                     s2_rgb;
   logic [2:0]               s2_emph;
   logic                     s2_nb, s2_hs, s2_vs;
   rgb_t                     shaded;
   rgb_t                     s3_rgb;
   logic                     vsync_d;
   logic                     vsync_fall;
   logic [P_frame_width-1:0] frame_q;

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         s1_index <= '0;
         s1_emph  <= '0;
         s1_nb    <= 1'b0;
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
         s2_emph  <= '0;
         s2_nb    <= 1'b0;
         s2_hs    <= 1'b1;
         s2_vs    <= 1'b1;
      end else if (I_rise) begin
         s1_index <= I_greyscale ? (I_pixel & 6'h30) : I_pixel;
         s1_emph  <= I_emphasis;
         s1_nb    <= I_not_blank;
         s1_hs    <= I_hsync;
         s1_vs    <= I_vsync;
         s2_emph  <= s1_emph;
         s2_nb    <= s1_nb;
         s2_hs    <= s1_hs;
         s2_vs    <= s1_vs;
      end
   end

   video_palette u_palette (
      .clock  (I_clock),
      .reset  (I_reset),
      .enable (I_rise),
      .index  (s1_index),
      .rgb    (s2_rgb)
   );

   // Emphasis dims the channels that are NOT selected; blanking overrides everything.
   always_comb begin
      shaded = s2_rgb;
      if (s2_emph != 3'b000) begin
         if (!s2_emph[0]) shaded.red   = dim(s2_rgb.red);
         if (!s2_emph[1]) shaded.green = dim(s2_rgb.green);
         if (!s2_emph[2]) shaded.blue  = dim(s2_rgb.blue);
      end
      if (!s2_nb) shaded = '0;
   end

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         s3_rgb      <= '0;
         O_not_blank <= 1'b0;
         O_hsync     <= 1'b1;
         O_vsync     <= 1'b1;
      end else if (I_rise) begin
         s3_rgb      <= shaded;
         O_not_blank <= s2_nb;
         O_hsync     <= s2_hs;
         O_vsync     <= s2_vs;
      end
   end

   assign O_red   = s3_rgb.red;
   assign O_green = s3_rgb.green;
   assign O_blue  = s3_rgb.blue;

   // vsync_d resets high so the reset value of O_vsync never looks like a falling edge.
   assign vsync_fall = vsync_d & ~O_vsync;

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         vsync_d       <= 1'b1;
         O_frame_start <= 1'b0;
         frame_q       <= '0;
      end else begin
         vsync_d       <= O_vsync;
         O_frame_start <= vsync_fall;
         if (vsync_fall) frame_q <= frame_q + P_frame_width'(1);
      end
   end

   assign O_frame = frame_q;

endmodule

// File: tb/tb_video_output_pipe.sv
// Directed bench for video_output_pipe: pipeline latency, greyscale, emphasis,
// blanking, sync alignment, frame counting with wrap, and mid-frame reset.
module tb_video_output_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rise = 1'b0;
   logic        not_blank = 1'b0;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic [5:0]  pixel = '0;
   logic        grey = 1'b0;
   logic [2:0]  emph = '0;
   logic [7:0]  red, green, blue;
   logic        o_nb, o_hs, o_vs;
   logic [15:0] frame;
   logic        frame_start;

   int n_tests = 0;
   int n_fail  = 0;
   int fs_count = 0;

   video_output_pipe #(.P_stages(3), .P_frame_width(16)) dut (
      .I_clock       (clk),
      .I_reset       (rst_n),
      .I_rise        (rise),
      .I_not_blank   (not_blank),
      .I_hsync       (hsync),
      .I_vsync       (vsync),
      .I_pixel       (pixel),
      .I_greyscale   (grey),
      .I_emphasis    (emph),
      .O_red         (red),
      .O_green       (green),
      .O_blue        (blue),
      .O_not_blank   (o_nb),
      .O_hsync       (o_hs),
      .O_vsync       (o_vs),
      .O_frame       (frame),
      .O_frame_start (frame_start)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // frame_start is high for whole clocks; counting at negedges counts clocks high
   always @(negedge clk) if (frame_start) fs_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One pixel strobe: inputs valid on the I_rise clock, garbage on the other three.
   task automatic push(input logic [5:0] p, input logic g, input logic [2:0] e,
                       input logic nb, input logic hs, input logic vs);
      @(negedge clk);
      pixel = p; grey = g; emph = e; not_blank = nb; hsync = hs; vsync = vs;
      rise = 1'b1;
      @(negedge clk);
      rise = 1'b0;
      pixel = 6'($urandom_range(0, 63));
      grey = 1'($urandom_range(0, 1));
      emph = 3'($urandom_range(0, 7));
      not_blank = 1'($urandom_range(0, 1));
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] exp);
      check(tag, {8'h00, red, green, blue}, {8'h00, exp});
   endtask

   // Directed vectors; expected output after push i reflects input of push i-2.
   localparam int N = 13;
   logic [5:0]  v_pix [N] = '{6'h30, 6'h30, 6'h30, 6'h30, 6'h16, 6'h16, 6'h30,
                              6'h30, 6'h10, 6'h16, 6'h00, 6'h00, 6'h00};
   logic        v_gr  [N] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
   logic [2:0]  v_em  [N] = '{3'd0, 3'd0, 3'd1, 3'd7, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd2, 3'd6, 3'd0, 3'd0, 3'd0};
   logic        v_nb  [N] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
   logic        v_hs  [N] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
   logic [23:0] x_rgb [N] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                              24'hFFC0C0, 24'hFFFFFF, 24'hBCBCBC, 24'hF83800,
                              24'h000000, 24'hFFFFFF, 24'h8DBC8D, 24'hBA3800,
                              24'h7C7C7C};
   logic        x_nb  [N] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
   logic        x_hs  [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};

   initial begin
      repeat (3) @(negedge clk);
      check("reset_rgb", {8'h00, red, green, blue}, 32'h0);
      check("reset_nb", {31'b0, o_nb}, 32'd0);
      check("reset_hs", {31'b0, o_hs}, 32'd1);
      check("reset_vs", {31'b0, o_vs}, 32'd1);
      check("reset_frame", {16'b0, frame}, 32'd0);
      check("reset_fs", {31'b0, frame_start}, 32'd0);
      rst_n = 1'b1;

      // latency, emphasis, greyscale, blanking, hsync alignment
      for (int i = 0; i < N; i++) begin
         push(v_pix[i], v_gr[i], v_em[i], v_nb[i], v_hs[i], 1'b1);
         check_rgb($sformatf("vec%0d_rgb", i), x_rgb[i]);
         check($sformatf("vec%0d_nb", i), {31'b0, o_nb}, {31'b0, x_nb[i]});
         check($sformatf("vec%0d_hs", i), {31'b0, o_hs}, {31'b0, x_hs[i]});
         check($sformatf("vec%0d_vs", i), {31'b0, o_vs}, 32'd1);
      end
      check("no_frame_yet", fs_count, 0);

      // two vsync pulses -> two one-clock frame_start pulses
      for (int f = 0; f < 2; f++) begin
         push(6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
         repeat (3) push(6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
      end
      check("frame_start_clocks", fs_count, 2);
      check("frame_count", {16'b0, frame}, 32'd2);

      // wrap from all-ones
      @(negedge clk);
      force dut.frame_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_q;
      check("frame_preload", {16'b0, frame}, 32'h0000FFFF);
      push(6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      repeat (3) push(6'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
      check("frame_wrap", {16'b0, frame}, 32'd0);
      check("frame_start_clocks_wrap", fs_count, 3);

      // mid-line reset: stream 0x16, reset, then stream 0x30
      repeat (3) push(6'h16, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
      check_rgb("pre_reset_rgb", 24'hF83800);
      check("pre_reset_hs", {31'b0, o_hs}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_rgb("async_reset_rgb", 24'h000000);
      check("async_reset_nb", {31'b0, o_nb}, 32'd0);
      check("async_reset_hs", {31'b0, o_hs}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      push(6'h30, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      check_rgb("post_reset_p0", 24'h000000);
      push(6'h30, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      check_rgb("post_reset_p1", 24'h000000);
      check("post_reset_nb1", {31'b0, o_nb}, 32'd0);
      push(6'h30, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      check_rgb("post_reset_p2", 24'hFFFFFF);
      check("post_reset_nb2", {31'b0, o_nb}, 32'd1);
      check("post_reset_frame", {16'b0, frame}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/video_output_pipe.md
Name: video_output_pipe

Overview:
- Downstream consumer of the video timing generator.
- Takes the per-pixel strobe, blanking and sync signals from the timing block, plus the PPU's 6-bit palette index and colour modifiers, and produces aligned 8-bit RGB with matching sync/blank for the display encoder.
- Runs in the system clock domain. Every pipeline register advances only on the pixel strobe.
- Also counts frames for software and debug.

Parameters:
- P_stages, 3, pipeline depth in pixel strobes. Fixed; exposed only for documentation and assertions.
- P_frame_width, 16, width of the frame counter.

Ports:
- I_clock  in  1  system clock.
- I_reset  in  1  reset, asynchronous, active-low.
- I_rise  in  1  pixel strobe from timing block; one-cycle pulse every 4 clocks.
- I_not_blank  in  1  high in the active picture.
- I_hsync  in  1  horizontal sync, active-low.
- I_vsync  in  1  vertical sync, active-low.
- I_pixel  in  6  palette index for the current pixel.
- I_greyscale  in  1  force greyscale column.
- I_emphasis  in  3  colour emphasis: bit0 R, bit1 G, bit2 B.
- O_red  out  8  red channel.
- O_green  out  8  green channel.
- O_blue  out  8  blue channel.
- O_not_blank  out  1  I_not_blank delayed to align with RGB.
- O_hsync  out  1  I_hsync delayed to align with RGB.
- O_vsync  out  1  I_vsync delayed to align with RGB.
- O_frame  out  P_frame_width  completed-frame count.
- O_frame_start  out  1  one-clock pulse at the start of the O_vsync assertion.

Behaviour:
- Reset (I_reset low, async):
  - RGB = 0; O_not_blank = 0; O_hsync = O_vsync = 1; O_frame = 0; O_frame_start = 0.
  - All internal stage registers go to the same inactive values.
- Reset mid-frame: the pipeline is discarded. After release, outputs stay at reset values until real data has propagated 3 strobes.
- Stage 1 (on I_rise):
  - Capture I_pixel, masked to index & 6'h30 when I_greyscale = 1.
  - Capture I_emphasis, I_not_blank, I_hsync, I_vsync.
- Stage 2 (on I_rise): registered palette lookup of the stage-1 index into 24-bit RGB. Emphasis, blank and syncs are carried alongside.
- Stage 3 (on I_rise): emphasis and blanking.
  - If emphasis = 0: each channel passes unchanged.
  - Otherwise, each channel whose emphasis bit is 0 becomes v - (v >> 2) (8-bit, floor, no overflow possible). Channels whose emphasis bit is 1 pass unchanged.
  - If the stage-2 not_blank is 0, RGB is forced to 0 regardless of index or emphasis.
  - Syncs and not_blank are registered unchanged.
- Latency:
  - Inputs sampled at strobe k appear on the outputs from the clock after strobe k+2.
  - They hold until the clock after strobe k+3.
  - Outputs change only in the clock following an I_rise.
- With no I_rise, all stages hold indefinitely.
- Frame count:
  - O_frame_start pulses for one clock when O_vsync goes from 1 to 0 (edge detected on the registered output).
  - O_frame increments in the same clock, wrapping from 2^P_frame_width - 1 to 0.
- No frame-start event occurs on the first cycle after reset, because the reset value of O_vsync is 1.
- Inputs changing between strobes are ignored; only the value at the I_rise clock matters.

Decomposition:
- Package video_pkg holds:
  - the 64-entry x 24-bit palette constant array C_palette (entries 0x0D/0x1D/0x2D/0x3D/0x0E/0x1E/0x2E/0x3E/0x0F/0x1F/0x2F/0x3F = 24'h000000; entry 0x30 = 24'hFFFFFF);
  - the pipeline depth constant;
  - the typedef rgb_t {red, green, blue: 8 bits each}.
- One sub-module, video_palette: registered 64x24 ROM with clock, reset, enable, index in, rgb_t out.

Test Plan:
- Reset then 3 strobes with I_pixel = 0x30, I_not_blank = 1, emphasis 0 → RGB = FF/FF/FF appears the clock after the 3rd strobe; not earlier.
- I_pixel = 0x30, I_emphasis = 3'b001 → R = FF, G = C0, B = C0. With I_emphasis = 3'b111 → FF/FF/FF.
- I_pixel = 0x16, I_greyscale = 1 → output equals C_palette[0x10]. With I_greyscale = 0 → output equals C_palette[0x16].
- I_not_blank = 0 with I_pixel = 0x30 → RGB = 0. Then drive a single-strobe hsync low pulse → O_hsync low for exactly one strobe period, aligned with the same-strobe pixel, 3 strobes late.
- Drive vsync low for 2 frames' worth of edges → O_frame_start pulses twice, one clock each, and O_frame = 2. Preload near wrap (force 16'hFFFF) → next edge gives 0.
- Assert I_reset low mid-line while pixels stream → outputs go to reset values immediately (async). After release, old pixels never reappear and the first valid RGB arrives 3 strobes later.
